// File: rtl/im_loader.sv
// im_loader: fills instruction memory from a big-endian byte stream while holding the CPU.
// Optional trailing XOR checksum enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int ADDR_W = 7,
    parameter int WORDS  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif
    state_t state, state_n;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_c;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        bcnt;
    logic [31:0]       word;
    logic              go;
    logic              take;
    logic              last;

    assign go    = start && (state == IDLE || state == DONE);
    assign take  = byte_valid && byte_ready;
    assign len_c = (load_len > (ADDR_W+1)'(WORDS)) ? (ADDR_W+1)'(WORDS) : load_len;
    assign last  = ((ADDR_W+1)'(idx) + (ADDR_W+1)'(1)) == len;
    assign im_addr  = idx;
    assign im_wdata = word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = (len_c != '0) ? LOAD : DONE;
            LOAD:       if (take && bcnt == 2'd3) state_n = WRITE;
`ifdef IM_LOADER_CHECKSUM_EN
            WRITE:      state_n = last ? CHECK : LOAD;
            CHECK:      if (take) state_n = DONE;
`else
            WRITE:      state_n = last ? DONE : LOAD;
`endif
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        im_we      = state == WRITE;
        done       = state == DONE;
`ifdef IM_LOADER_CHECKSUM_EN
        byte_ready = state == LOAD || state == CHECK;
        cpu_hold   = state == LOAD || state == WRITE || state == CHECK || (state == DONE && err);
`else
        byte_ready = state == LOAD;
        cpu_hold   = state == LOAD || state == WRITE;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len  <= '0;
            idx  <= '0;
            bcnt <= '0;
            word <= '0;
        end else begin
            if (go) begin
                len  <= len_c;
                idx  <= '0;
                bcnt <= '0;
            end
            if (state == LOAD && take) begin
                word <= {word[23:0], byte_data};
                bcnt <= bcnt + 2'd1;
            end
            // Hold the index on the final word so the address never wraps past WORDS-1.
            if (state == WRITE && !last) idx <= idx + ADDR_W'(1);
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            if (go) begin
                csum <= '0;
                err  <= 1'b0;
            end
            if (state == LOAD && take) csum <= csum ^ byte_data;
            if (state == CHECK && take && byte_data != csum) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
